prog_loader: RTL

Serial program loader that writes the instruction memory the single-cycle ARM core fetches from. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them to consecutive word addresses. It verifies a trailing XOR checksum, then releases the core by raising CPU_RUN. It sits between the host/UART byte source and the instruction memory write port, alongside the arm top.

---
 rtl/loader_pkg.sv | 20 ++
 rtl/word_assembler.sv | 54 +++++
 rtl/prog_loader.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and frame constants for the program loader
package loader_pkg;

    localparam logic [2:0] S_LEN_LO = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_CSUM   = 3'd4;
    localparam logic [2:0] S_RUN    = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    // States in which the loader is willing to take a stream byte.
    function automatic logic state_accepts(input logic [2:0] s);
        return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - packs little-endian stream bytes into 32-bit words
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_next_o,
    output logic        full_o,
    output logic        last_lane_o
);

    localparam logic [1:0] LAST_LANE = 2'(WORD_BYTES - 1);

    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] word_q, word_d;
    logic        full_q, full_d;

    // Lane insert and counter advance; word_next exposes the word including this byte.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        full_d     = full_q;
        if (clear_i) begin
            byte_cnt_d = 2'd0;
            word_d     = 32'd0;
            full_d     = 1'b0;
        end else if (accept_i) begin
            word_d[{byte_cnt_q, 3'b000} +: 8] = byte_i;
            byte_cnt_d = byte_cnt_q + 2'd1;
            full_d     = (byte_cnt_q == LAST_LANE);
        end
    end

    // Assembly state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_cnt_q <= 2'd0;
            word_q     <= 32'd0;
            full_q     <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            full_q     <= full_d;
        end
    end

    assign word_next_o = word_d;
    assign full_o      = full_q;
    assign last_lane_o = (byte_cnt_q == LAST_LANE);

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader with XOR checksum and core release
module prog_loader
    import loader_pkg::*;
#(
    parameter int          MAX_WORDS = 64,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        BYTE_VALID,
    input  logic [7:0]  BYTE_DATA,
    output logic        BYTE_READY,
    input  logic        RELOAD,
    output logic        IMEM_WE,
    output logic [31:0] IMEM_ADDR,
    output logic [31:0] IMEM_WDATA,
    output logic        CPU_RUN,
    output logic        DONE,
    output logic        ERR
);

    localparam int             LEN_W = 8 * LEN_BYTES;
    localparam logic [LEN_W-1:0] MAX_N = LEN_W'(MAX_WORDS);

    logic [2:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [7:0]       csum_q, csum_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             run_q, run_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             accept;
    logic             reload_ok;
    logic [LEN_W-1:0] len_full;
    logic [LEN_W-1:0] idx_inc;
    logic [31:0]      asm_word_next;
    logic             asm_full;
    logic             asm_last;

    // Ready is a pure state decode, forced low while reset is held.
    assign BYTE_READY = RESETn && state_accepts(state_q);
    assign accept     = BYTE_VALID && BYTE_READY;
    assign reload_ok  = RELOAD && ((state_q == S_RUN) || (state_q == S_ERR));
    assign len_full   = {BYTE_DATA, len_q[7:0]};
    assign idx_inc    = idx_q + LEN_W'(1);

    word_assembler u_asm (
        .clk_i       (CLK),
        .rst_ni      (RESETn),
        .clear_i     (reload_ok),
        .accept_i    (accept && (state_q == S_DATA)),
        .byte_i      (BYTE_DATA),
        .word_next_o (asm_word_next),
        .full_o      (asm_full),
        .last_lane_o (asm_last)
    );

    // Frame sequencing, running checksum and write address/data capture.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        if (accept && (state_q != S_CSUM)) begin
            csum_d = csum_q ^ BYTE_DATA;
        end

        case (state_q)
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = BYTE_DATA;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_full > MAX_N) begin
                        state_d = S_ERR;
                    end else if (len_full == '0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && asm_last) begin
                    addr_d  = ADDR_BASE + {{(30-LEN_W){1'b0}}, idx_q, 2'b00};
                    wdata_d = asm_word_next;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                idx_d   = idx_inc;
                state_d = (idx_inc == len_q) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (accept) begin
                    state_d = (BYTE_DATA == csum_q) ? S_RUN : S_ERR;
                end
            end
            S_RUN, S_ERR: begin
                if (RELOAD) begin
                    state_d = S_LEN_LO;
                    len_d   = '0;
                    idx_d   = '0;
                    csum_d  = 8'd0;
                end
            end
            default: begin
                state_d = S_LEN_LO;
            end
        endcase

        run_d  = (state_d == S_RUN);
        done_d = (state_d == S_RUN);
        err_d  = (state_d == S_ERR);
    end

    // Loader state registers; a reset mid-frame discards everything in flight.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= S_LEN_LO;
            len_q   <= '0;
            idx_q   <= '0;
            csum_q  <= 8'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            run_q   <= run_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign IMEM_WE    = (state_q == S_WRITE) && asm_full;
    assign IMEM_ADDR  = addr_q;
    assign IMEM_WDATA = wdata_q;
    assign CPU_RUN    = run_q;
    assign DONE       = done_q;
    assign ERR        = err_q;

endmodule
